// File: rtl/vga_timing_pkg.sv
// Shared 800x600 @ 72 Hz VGA timing constants for the tank game display path.
// The pixel-coordinate stage downstream reuses H_ACTIVE/V_ACTIVE from here.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FP     = 56;
  localparam int unsigned H_SYNC   = 120;
  localparam int unsigned H_BP     = 64;
  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned V_FP     = 37;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 23;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned HC_W     = 11;
  localparam int unsigned VC_W     = 10;

endpackage

// File: rtl/game_dst_sync_cnt.sv
// Generic wrap counter: counts 0..TOTAL-1 while enabled, o_tc flags the last count.
module sync_cnt #(
  parameter int unsigned W     = 11,
  parameter int unsigned TOTAL = 1040
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
    end
  end

  assign o_tc  = (r_cnt == LAST);
  assign o_cnt = r_cnt;

endmodule

// File: rtl/game_dst.sv
// VGA sync timing generator: line/frame counters plus registered decode of
// active enables, sync pulses and the once-per-frame tick/counter.
module game_dst
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        pclk,
  input  logic        rstn,
  output logic        hen,
  output logic        ven,
  output logic        hs,
  output logic        vs,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries as counter-width constants so every compare is unsigned.
  localparam logic [HC_W-1:0] HEN_END = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] VEN_END = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HC_W-1:0] w_hcnt;
  logic [VC_W-1:0] w_vcnt;
  logic            w_h_tc;
  logic            w_v_tc;

  sync_cnt #(
    .W     (HC_W),
    .TOTAL (H_TOT)
  ) u_hcnt (
    .i_clk   (pclk),
    .i_rst_n (rstn),
    .i_en    (1'b1),
    .o_cnt   (w_hcnt),
    .o_tc    (w_h_tc)
  );

  sync_cnt #(
    .W     (VC_W),
    .TOTAL (V_TOT)
  ) u_vcnt (
    .i_clk   (pclk),
    .i_rst_n (rstn),
    .i_en    (w_h_tc),
    .o_cnt   (w_vcnt),
    .o_tc    (w_v_tc)
  );

  logic w_hen_d;
  logic w_ven_d;
  logic w_hs_d;
  logic w_vs_d;
  logic w_tick_d;

  // vs is decoded from vcnt alone, so it only moves on the line wrap.
  assign w_hen_d  = (w_hcnt < HEN_END);
  assign w_ven_d  = (w_vcnt < VEN_END);
  assign w_hs_d   = (w_hcnt >= HS_BEG) && (w_hcnt < HS_END);
  assign w_vs_d   = (w_vcnt >= VS_BEG) && (w_vcnt < VS_END);
  assign w_tick_d = (w_vcnt == VEN_END) && (w_hcnt == '0);

  logic        r_hen;
  logic        r_ven;
  logic        r_hs;
  logic        r_vs;
  logic        r_tick;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_hen       <= 1'b0;
      r_ven       <= 1'b0;
      r_hs        <= ~HS_POL;
      r_vs        <= ~VS_POL;
      r_tick      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_hen  <= w_hen_d;
      r_ven  <= w_ven_d;
      r_hs   <= w_hs_d ? HS_POL : ~HS_POL;
      r_vs   <= w_vs_d ? VS_POL : ~VS_POL;
      r_tick <= w_tick_d;
      if (w_tick_d) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign hen        = r_hen;
  assign ven        = r_ven;
  assign hs         = r_hs;
  assign vs         = r_vs;
  assign frame_tick = r_tick;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_game_dst.sv
// Self-checking bench for game_dst: a default-mode instance for line timing and a
// shrunken-mode instance so whole frames fit in a short run.
module tb_game_dst;

  localparam int SH_A  = 16;
  localparam int SH_FP = 4;
  localparam int SH_S  = 6;
  localparam int SH_BP = 4;
  localparam int SV_A  = 10;
  localparam int SV_FP = 3;
  localparam int SV_S  = 2;
  localparam int SV_BP = 3;
  localparam int SHT   = SH_A + SH_FP + SH_S + SH_BP;
  localparam int SVT   = SV_A + SV_FP + SV_S + SV_BP;
  localparam int SFR   = SHT * SVT;

  typedef struct packed {
    logic        hen;
    logic        ven;
    logic        hs;
    logic        vs;
    logic        tick;
    logic [15:0] fcnt;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rstn = 1'b0;

  logic        sHen, sVen, sHs, sVs, sTick;
  logic [15:0] sFcnt;
  logic        dHen, dVen, dHs, dVs, dTick;
  logic [15:0] dFcnt;

  int   nTests = 0;
  int   nFail  = 0;
  exp_t sbQ[$];

  // 100 MHz-equivalent bench clock; only the cycle count matters here.
  always #5 pclk = ~pclk;

  game_dst #(
    .H_ACTIVE (SH_A), .H_FP (SH_FP), .H_SYNC (SH_S), .H_BP (SH_BP),
    .V_ACTIVE (SV_A), .V_FP (SV_FP), .V_SYNC (SV_S), .V_BP (SV_BP),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dutS (
    .pclk (pclk), .rstn (rstn), .hen (sHen), .ven (sVen), .hs (sHs),
    .vs (sVs), .frame_tick (sTick), .frame_cnt (sFcnt)
  );

  game_dst dutD (
    .pclk (pclk), .rstn (rstn), .hen (dHen), .ven (dVen), .hs (dHs),
    .vs (dVs), .frame_tick (dTick), .frame_cnt (dFcnt)
  );

  // Reference for the shrunken instance: n is the number of cycles since reset
  // release, i.e. the counter position the output sampled after edge n+1 reflects.
  function automatic exp_t model(input int n);
    int   h;
    int   v;
    exp_t e;
    h      = n % SHT;
    v      = (n / SHT) % SVT;
    e.hen  = (h < SH_A);
    e.ven  = (v < SV_A);
    e.hs   = (h >= SH_A + SH_FP) && (h < SH_A + SH_FP + SH_S);
    e.vs   = (v >= SV_A + SV_FP) && (v < SV_A + SV_FP + SV_S);
    e.tick = (v == SV_A) && (h == 0);
    e.fcnt = (n < SV_A * SHT) ? 16'd0 : 16'((n - SV_A * SHT) / SFR + 1);
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge pclk);
    rstn = 1'b0;
    repeat (2) @(negedge pclk);
    rstn = 1'b1;
    sbQ.delete();
  endtask

  task automatic test_reset();
    exp_t act;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      act = {sHen, sVen, sHs, sVs, sTick, sFcnt};
      nTests++;
      if (act !== '0) begin
        nFail++;
        $display("[TB] FAIL reset_small got %h expected 0", act);
      end
      act = {dHen, dVen, dHs, dVs, dTick, dFcnt};
      nTests++;
      if (act !== '0) begin
        nFail++;
        $display("[TB] FAIL reset_default got %h expected 0", act);
      end
    end
    rstn = 1'b1;
    @(posedge pclk);
    #1;
    act = {sHen, sVen, sHs, sVs, sTick, sFcnt};
    nTests++;
    if (act !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      nFail++;
      $display("[TB] FAIL first_edge_small got %h expected %h", act,
               {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    end
    act = {dHen, dVen, dHs, dVs, dTick, dFcnt};
    nTests++;
    if (act !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      nFail++;
      $display("[TB] FAIL first_edge_default got %h expected %h", act,
               {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    end
  endtask

  task automatic test_line();
    int henHigh  = 0;
    int henFalls = 0;
    int venLow   = 0;
    int hsFirst  = -1;
    int hsLast   = -1;
    logic prevHen = 1'b0;
    apply_reset();
    for (int n = 0; n <= 1040; n++) begin
      @(posedge pclk);
      #1;
      if (n < 1040) begin
        if (dHen) henHigh++;
        if (prevHen && !dHen) henFalls++;
        if (!dVen) venLow++;
        if (dHs && hsFirst < 0) hsFirst = n;
        if (dHs) hsLast = n;
        prevHen = dHen;
      end else begin
        nTests++;
        if (dHen !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL line_period hen at 1040 got %b expected 1", dHen);
        end
      end
    end
    nTests++;
    if (henHigh != 800) begin
      nFail++;
      $display("[TB] FAIL hen_width got %0d expected 800", henHigh);
    end
    nTests++;
    if (hsFirst != 856) begin
      nFail++;
      $display("[TB] FAIL hs_start got %0d expected 856", hsFirst);
    end
    nTests++;
    if (hsLast != 975) begin
      nFail++;
      $display("[TB] FAIL hs_end got %0d expected 975", hsLast);
    end
    nTests++;
    if (henFalls != 1) begin
      nFail++;
      $display("[TB] FAIL hen_falls_line got %0d expected 1", henFalls);
    end
    nTests++;
    if (venLow != 0) begin
      nFail++;
      $display("[TB] FAIL ven_line0 low cycles got %0d expected 0", venLow);
    end
  endtask

  task automatic test_frames();
    exp_t act;
    exp_t exp;
    int   henFalls = 0;
    int   venFalls = 0;
    int   tickWhileVen = 0;
    int   tickCount = 0;
    int   tickAt[2] = '{-1, -1};
    logic prevHen = 1'b0;
    logic prevVen = 1'b0;
    apply_reset();
    for (int n = 0; n < 2 * SFR + SHT; n++) begin
      sbQ.push_back(model(n));
      @(posedge pclk);
      #1;
      act = {sHen, sVen, sHs, sVs, sTick, sFcnt};
      exp = sbQ.pop_front();
      nTests++;
      if (act !== exp) begin
        nFail++;
        $display("[TB] FAIL frame_cycle n=%0d got %h expected %h", n, act, exp);
      end
      if (n >= 1 && n <= SFR) begin
        if (prevHen && !sHen) henFalls++;
        if (prevVen && !sVen) venFalls++;
      end
      if (sTick && sVen) tickWhileVen++;
      if (sTick) begin
        if (tickCount < 2) tickAt[tickCount] = n;
        tickCount++;
      end
      prevHen = sHen;
      prevVen = sVen;
    end
    nTests++;
    if (henFalls != SVT) begin
      nFail++;
      $display("[TB] FAIL hen_falls_frame got %0d expected %0d", henFalls, SVT);
    end
    nTests++;
    if (venFalls != 1) begin
      nFail++;
      $display("[TB] FAIL ven_falls_frame got %0d expected 1", venFalls);
    end
    nTests++;
    if (tickWhileVen != 0) begin
      nFail++;
      $display("[TB] FAIL tick_during_ven got %0d expected 0", tickWhileVen);
    end
    nTests++;
    if (tickCount != 2 || tickAt[0] != SV_A * SHT || tickAt[1] - tickAt[0] != SFR) begin
      nFail++;
      $display("[TB] FAIL tick_spacing got count %0d at %0d,%0d expected 2 at %0d,%0d",
               tickCount, tickAt[0], tickAt[1], SV_A * SHT, SV_A * SHT + SFR);
    end
    nTests++;
    if (sFcnt !== 16'd2) begin
      nFail++;
      $display("[TB] FAIL frame_cnt_two got %0d expected 2", sFcnt);
    end
  endtask

  task automatic test_async_reset();
    exp_t act;
    exp_t exp;
    apply_reset();
    // Stop in the second frame at line 5, pixel 8, after one frame has counted.
    for (int n = 0; n < SFR + 5 * SHT + 8; n++) begin
      @(posedge pclk);
    end
    #1;
    nTests++;
    if (sFcnt !== 16'd1) begin
      nFail++;
      $display("[TB] FAIL pre_reset_frame_cnt got %0d expected 1", sFcnt);
    end
    #2;
    rstn = 1'b0;
    #1;
    act = {sHen, sVen, sHs, sVs, sTick, sFcnt};
    nTests++;
    if (act !== '0) begin
      nFail++;
      $display("[TB] FAIL async_reset_outputs got %h expected 0", act);
    end
    nTests++;
    if (dutS.w_hcnt !== '0 || dutS.w_vcnt !== '0) begin
      nFail++;
      $display("[TB] FAIL async_reset_counters got h=%0d v=%0d expected 0,0",
               dutS.w_hcnt, dutS.w_vcnt);
    end
    @(negedge pclk);
    rstn = 1'b1;
    sbQ.delete();
    for (int n = 0; n < 2 * SHT; n++) begin
      sbQ.push_back(model(n));
      @(posedge pclk);
      #1;
      act = {sHen, sVen, sHs, sVs, sTick, sFcnt};
      exp = sbQ.pop_front();
      nTests++;
      if (act !== exp) begin
        nFail++;
        $display("[TB] FAIL restart_cycle n=%0d got %h expected %h", n, act, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic seen = 1'b0;
    apply_reset();
    repeat (5) @(posedge pclk);
    #1;
    force dutS.r_frame_cnt = 16'hFFFF;
    #1;
    release dutS.r_frame_cnt;
    for (int k = 0; k < SFR && !seen; k++) begin
      @(posedge pclk);
      #1;
      if (sTick) seen = 1'b1;
    end
    nTests++;
    if (!seen) begin
      nFail++;
      $display("[TB] FAIL wrap_tick_timeout got no tick expected one within %0d cycles", SFR);
    end
    nTests++;
    if (sFcnt !== 16'h0000) begin
      nFail++;
      $display("[TB] FAIL frame_cnt_wrap got %h expected 0000", sFcnt);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/game_dst.md
# game_dst

Display sync timing generator for the tank game's 800x600 @ 72 Hz VGA output, clocked by the 50 MHz pixel clock. Sits directly upstream of the game pixel-coordinate stage. Produces the following signals:
- `hen`/`ven` active-area enables consumed by that stage.
- `hs`/`vs` sync pins driven to the connector.
- A once-per-frame `frame_tick` and a frame counter, used by game logic to step state during vertical blanking.

## Interface
Parameters:
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 56, horizontal front porch (pclk cycles)
- `H_SYNC`, 120, horizontal sync width
- `H_BP`, 64, horizontal back porch
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 37, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width
- `V_BP`, 23, vertical back porch
- `HS_POL`, 1, asserted level of `hs`
- `VS_POL`, 1, asserted level of `vs`

Ports:
- `pclk` in 1: pixel clock, 50 MHz; only clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `hen` out 1: horizontal active-area enable.
- `ven` out 1: vertical active-area enable.
- `hs` out 1: horizontal sync, level per `HS_POL`.
- `vs` out 1: vertical sync, level per `VS_POL`.
- `frame_tick` out 1: one-cycle pulse at start of vertical blanking.
- `frame_cnt` out 16: frames completed since reset; wraps.

## Operation
Derived constants:
- `H_TOTAL` = `H_ACTIVE` + `H_FP` + `H_SYNC` + `H_BP` = 1040.
- `V_TOTAL` = `V_ACTIVE` + `V_FP` + `V_SYNC` + `V_BP` = 666.

Counters:
- `hcnt` is 11-bit; counts 0..`H_TOTAL`-1 every cycle, then wraps to 0.
- `vcnt` is 10-bit; increments only on the `hcnt` wrap cycle, counts 0..`V_TOTAL`-1, then wraps to 0.

Line layout, active first: active, front porch, sync, back porch.
- `hen` asserted when `hcnt` < `H_ACTIVE`.
- `hs` asserted when `H_ACTIVE`+`H_FP` <= `hcnt` < `H_ACTIVE`+`H_FP`+`H_SYNC`, i.e. 856..975.

Frame layout, same ordering.
- `ven` asserted when `vcnt` < `V_ACTIVE`.
- `vs` asserted when 637 <= `vcnt` < 643.
- `vs` changes only at line boundaries, aligned with the `hcnt` wrap.

Frame events:
- `frame_tick` fires when `vcnt`==`V_ACTIVE` and `hcnt`==0.
- `frame_cnt` increments on that same cycle and wraps 0xFFFF -> 0.

Hardware constraints:
- Compare boundaries are parameter-derived constants; no run-time configuration.
- No multipliers.
- All comparisons are unsigned, at counter width.

Reset, asynchronous, while `rstn`=0:
- `hcnt`=0, `vcnt`=0.
- `hen`=0, `ven`=0, `frame_tick`=0, `frame_cnt`=0.
- `hs`=~`HS_POL`, `vs`=~`VS_POL`, i.e. deasserted.
- Reset asserted mid-line or mid-frame forces these values immediately, regardless of clock.
- The first frame after release begins at `hcnt`=0, `vcnt`=0.

## Timing
- Every output is registered, decoded from the counter values of the previous cycle. Latency from counter to output is 1 cycle; all outputs are mutually aligned.
- First `pclk` edge after `rstn` release: `hen`=1, `ven`=1, with counters at 0 before the edge.
- `hen` high for exactly 800 consecutive cycles per line, low for 240.
- `ven` high for exactly 600 lines x 1040 cycles.
- `hs` pulse is 120 cycles; `vs` pulse is 6 x 1040 = 6240 cycles.
- Frame period is 1040 x 666 = 692640 cycles.
- `frame_tick` is high for exactly 1 cycle per frame, 1 cycle after the last active line's final `hen` high period plus its blanking, i.e. on the first cycle of line 600.
- `frame_tick` never coincides with `ven`=1.
- `hen` falls exactly once per line, including blank lines. The downstream stage relies on this to advance its row counter.
- `ven` falls exactly once per frame, on the same cycle `hen` rises for line 600's position. `hen` continues toggling through blanking.

## Structure
- Shared package `vga_timing_pkg` holds:
  - The eight timing defaults plus `H_TOTAL`/`V_TOTAL` as localparams, for the 800x600 @ 72 Hz mode.
  - Counter widths `HC_W`=11 and `VC_W`=10.
  - The downstream coordinate stage reuses the `H_ACTIVE`/`V_ACTIVE` values.
- Optional sub-module `sync_cnt`:
  - Generic wrap counter with `tc` (terminal count) output and count-enable input.
  - Instantiated twice: horizontal, always enabled; vertical, enabled by horizontal `tc`.
  - The output decode stays in `game_dst`.

## Test plan
- Reset held, then released -> all outputs at their reset values during reset. One cycle after release: `hen`=1, `ven`=1, `hs`=0, `vs`=0.
- Run one full line -> `hen` high 800 cycles. `hs` high from cycle 856 to cycle 975 inclusive, relative to line start. Line period is 1040.
- Run two full frames:
  - `ven` high 600 lines.
  - `vs` high lines 637..642.
  - `frame_tick` exactly one pulse per frame, 692640 cycles apart.
  - `frame_cnt` goes 0 -> 1 -> 2.
- Count `hen` falling edges per frame -> 666. Count `ven` falling edges -> 1. No `frame_tick` while `ven`=1.
- Assert `rstn` asynchronously mid-frame, at line 300 pixel 400, between clock edges -> outputs and counters reset without waiting for an edge. Restart resumes at line 0, and `frame_cnt` restarts at 0.
- Preload `frame_cnt` to 0xFFFF via force -> next `frame_tick` wraps it to 0x0000.
